// File: rtl/elevator_pkg.sv
// Types and constants shared by the elevator cabin models and controllers.
package elevator_pkg;

    typedef logic signed [7:0] temp_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } model_state_t;

    localparam int TEMP_MIN_DEFAULT = -40;
    localparam int TEMP_MAX_DEFAULT = 85;
    localparam int TEMP_SETPOINT    = 25;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle pulse every DIV enabled cycles.
module tick_prescaler #(
    parameter int DIV = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic pulse
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) count <= '0;
            else               count <= count + CW'(1);
        end
    end

    assign pulse = enable && (count == LAST);

endmodule

// File: rtl/cabin_temp_model.sv
// Cabin thermal plant: actuator-driven temperature with drift toward ambient,
// clamped to a safe range, with latched detection of heater/cooler conflict.
module cabin_temp_model
    import elevator_pkg::*;
#(
    parameter int TICK_DIV       = 16,
    parameter int DRIFT_DIV      = 4,
    parameter int HEAT_STEP      = 2,
    parameter int COOL_STEP      = 2,
    parameter int INIT_TEMP      = 20,
    parameter int TEMP_MIN       = TEMP_MIN_DEFAULT,
    parameter int TEMP_MAX       = TEMP_MAX_DEFAULT,
    parameter int CONFLICT_LIMIT = 3
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  cooler,
    input  logic  heater,
    input  temp_t ambient,
    input  logic  freeze,
    output temp_t temp,
    output logic  temp_valid,
    output logic  tick,
    output logic  at_limit,
    output logic  fault
);

    localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
    localparam int KW = $clog2(CONFLICT_LIMIT + 1);
    localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);
    localparam logic [KW-1:0] CONF_MAX   = KW'(CONFLICT_LIMIT);
    localparam logic signed [9:0] LO     = 10'(TEMP_MIN);
    localparam logic signed [9:0] HI     = 10'(TEMP_MAX);

    model_state_t     state;
    temp_t            temp_q;
    logic [DW-1:0]    drift_cnt;
    logic [KW-1:0]    conf_cnt;

    logic             drift_hit;
    logic signed [9:0] delta;
    logic signed [9:0] sum;
    temp_t            next_temp;
    logic [KW-1:0]    conf_next;
    logic             conf_trip;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (state != INIT),
        .pulse  (tick)
    );

    // 10-bit arithmetic keeps the intermediate sum clear of 8-bit wrap before clamping.
    always_comb begin
        drift_hit = (drift_cnt == DRIFT_LAST);
        delta     = (heater ? 10'(HEAT_STEP) : 10'sd0) - (cooler ? 10'(COOL_STEP) : 10'sd0);
        if (drift_hit) begin
            if (ambient > temp_q)      delta = delta + 10'sd1;
            else if (ambient < temp_q) delta = delta - 10'sd1;
        end
        sum = 10'(temp_q) + delta;
        if (sum > HI)      next_temp = temp_t'(HI);
        else if (sum < LO) next_temp = temp_t'(LO);
        else               next_temp = temp_t'(sum);
    end

    always_comb begin
        conf_next = '0;
        if (cooler && heater)
            conf_next = (conf_cnt == CONF_MAX) ? conf_cnt : conf_cnt + KW'(1);
        conf_trip = (conf_next == CONF_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            temp_q     <= temp_t'(INIT_TEMP);
            temp_valid <= 1'b0;
            fault      <= 1'b0;
            drift_cnt  <= '0;
            conf_cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    state      <= RUN;
                    temp_valid <= 1'b1;
                end
                RUN: begin
                    if (tick) begin
                        conf_cnt <= conf_next;
                        if (!freeze) begin
                            temp_q    <= next_temp;
                            drift_cnt <= drift_hit ? '0 : drift_cnt + DW'(1);
                        end
                        if (conf_trip) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    fault      <= 1'b1;
                    temp_valid <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign temp     = temp_q;
    assign at_limit = (temp_q == temp_t'(TEMP_MIN)) || (temp_q == temp_t'(TEMP_MAX));

endmodule

// File: tb/tb_cabin_temp_model.sv
// Directed bench for the cabin thermal plant model.
module tb_cabin_temp_model;
    import elevator_pkg::*;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  cooler = 1'b0;
    logic  heater = 1'b0;
    logic  freeze = 1'b0;
    temp_t ambient = 8'sd20;
    temp_t ambient_hot = 8'sd84;

    temp_t temp, temp_hot;
    logic  temp_valid, tick, at_limit, fault;
    logic  temp_valid_hot, tick_hot, at_limit_hot, fault_hot;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cabin_temp_model u_main (
        .clock      (clock),
        .reset      (reset),
        .cooler     (cooler),
        .heater     (heater),
        .ambient    (ambient),
        .freeze     (freeze),
        .temp       (temp),
        .temp_valid (temp_valid),
        .tick       (tick),
        .at_limit   (at_limit),
        .fault      (fault)
    );

    cabin_temp_model #(.INIT_TEMP(84)) u_hot (
        .clock      (clock),
        .reset      (reset),
        .cooler     (cooler),
        .heater     (heater),
        .ambient    (ambient_hot),
        .freeze     (freeze),
        .temp       (temp_hot),
        .temp_valid (temp_valid_hot),
        .tick       (tick_hot),
        .at_limit   (at_limit_hot),
        .fault      (fault_hot)
    );

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tick_settle(output bit ok);
        wait_tick(ok);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int ticks;
        reset = 1'b1; cooler = 0; heater = 0; freeze = 0; ambient = 8'sd20;
        repeat (2) @(negedge clock);
        checks++; if (temp !== 8'sd20) begin errors++; $display("FAIL reset_temp got %0d want 20", temp); end
        checks++; if (temp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", temp_valid); end
        checks++; if (tick !== 1'b0 || fault !== 1'b0 || at_limit !== 1'b0) begin errors++; $display("FAIL reset_flags got tick=%b fault=%b at_limit=%b want 0", tick, fault, at_limit); end
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) begin
                checks++; if (temp_valid !== 1'b1) begin errors++; $display("FAIL valid_rise got %b want 1", temp_valid); end
            end
            if (tick) begin n = i; break; end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL first_tick_cycle got %0d want 16", n); end
        ticks = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            if (tick) ticks++;
        end
        checks++; if (ticks != 3) begin errors++; $display("FAIL idle_tick_count got %0d want 3", ticks); end
        checks++; if (temp !== 8'sd20) begin errors++; $display("FAIL idle_temp got %0d want 20", temp); end
    endtask

    task automatic test_heater();
        bit ok;
        int exp_t[4] = '{22, 24, 26, 27};
        heater = 1; cooler = 0; freeze = 0; ambient = 8'sd20;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick_settle(ok);
            checks++; if (!ok) begin errors++; $display("FAIL heater_tick_timeout got none want tick %0d", i + 1); end
            checks++; if (temp !== temp_t'(exp_t[i])) begin errors++; $display("FAIL heater_temp tick %0d got %0d want %0d", i + 1, temp, exp_t[i]); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", tick); end
        end
        heater = 0;
    endtask

    task automatic test_drift();
        bit ok;
        int exp_t[4] = '{20, 20, 20, 19};
        heater = 0; cooler = 0; freeze = 0; ambient = -8'sd10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick_settle(ok);
            checks++; if (!ok || temp !== temp_t'(exp_t[i])) begin errors++; $display("FAIL drift_temp tick %0d got %0d want %0d", i + 1, temp, exp_t[i]); end
        end
        ambient = 8'sd20;
    endtask

    task automatic test_clamp();
        bit ok;
        heater = 1; cooler = 0; freeze = 0;
        do_reset();
        @(negedge clock);
        checks++; if (temp_hot !== 8'sd84 || at_limit_hot !== 1'b0) begin errors++; $display("FAIL clamp_start got %0d/%b want 84/0", temp_hot, at_limit_hot); end
        for (int i = 0; i < 5; i++) begin
            tick_settle(ok);
            checks++; if (!ok || temp_hot !== 8'sd85) begin errors++; $display("FAIL clamp_temp tick %0d got %0d want 85", i + 1, temp_hot); end
            checks++; if (at_limit_hot !== 1'b1) begin errors++; $display("FAIL clamp_at_limit got %b want 1", at_limit_hot); end
        end
        heater = 0;
    endtask

    task automatic test_conflict();
        bit ok;
        cooler = 1; heater = 1; freeze = 0; ambient = 8'sd20;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick_settle(ok);
            checks++; if (!ok || temp !== 8'sd20) begin errors++; $display("FAIL conflict_temp tick %0d got %0d want 20", i, temp); end
            checks++; if (fault !== (i == 3)) begin errors++; $display("FAIL conflict_fault tick %0d got %b want %b", i, fault, (i == 3)); end
        end
        checks++; if (temp_valid !== 1'b1) begin errors++; $display("FAIL fault_valid got %b want 1", temp_valid); end
        cooler = 0; heater = 1;
        for (int i = 0; i < 2; i++) begin
            tick_settle(ok);
            checks++; if (!ok) begin errors++; $display("FAIL fault_tick_timeout got none want tick"); end
            checks++; if (temp !== 8'sd20 || fault !== 1'b1) begin errors++; $display("FAIL fault_frozen got %0d/%b want 20/1", temp, fault); end
        end
        cooler = 0; heater = 0;
        do_reset();
        checks++; if (temp !== 8'sd20 || fault !== 1'b0) begin errors++; $display("FAIL fault_reset got %0d/%b want 20/0", temp, fault); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic both_seq[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        freeze = 0; ambient = 8'sd20;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cooler = both_seq[i]; heater = both_seq[i];
            tick_settle(ok);
            checks++; if (!ok || fault !== 1'b0) begin errors++; $display("FAIL conflict_clear tick %0d got fault=%b want 0", i + 1, fault); end
        end
        cooler = 0; heater = 0;
    endtask

    task automatic test_freeze();
        bit ok;
        heater = 1; cooler = 0; freeze = 1; ambient = 8'sd20;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick_settle(ok);
            checks++; if (!ok || temp !== 8'sd20) begin errors++; $display("FAIL freeze_temp tick %0d got %0d want 20", i + 1, temp); end
        end
        freeze = 0;
        tick_settle(ok);
        checks++; if (!ok || temp !== 8'sd22) begin errors++; $display("FAIL unfreeze_temp got %0d want 22", temp); end
        heater = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        cooler = 0; heater = 0; freeze = 0;
        do_reset();
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (tick) begin n = i; break; end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL mid_reset_tick got %0d want 16", n); end
    endtask

    initial begin
        test_reset();
        test_heater();
        test_drift();
        test_clamp();
        test_conflict();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
